mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: data cache has priority, bounded by a starvation
// counter that forces an instruction grant after STARVE_LIMIT data completions.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int WORD_W       = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  input  logic [1:0]        ramstate,
  input  logic [WORD_W-1:0] ramload,
  output logic              iwait,
  output logic              dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  output logic              ramREN,
  output logic              ramWEN,
  output logic              ramerr
);

  localparam int            CW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT     = CW'(STARVE_LIMIT);
  localparam logic [1:0]    RS_ACCESS = 2'b10;
  localparam logic [1:0]    RS_ERROR  = 2'b11;

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          dreq, starving, i_done, d_done;

  assign dreq     = dREN | dWEN;
  assign starving = iREN && (starve_cnt_q == LIMIT);

  // RAM-side outputs are decoded from the current grant and live requester
  // inputs so a dropped request or a completion is seen in the same cycle.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iload        = '0;
    dload        = '0;
    ramerr       = 1'b0;
    iwait        = iREN;
    dwait        = dreq;
    i_done       = 1'b0;
    d_done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq && !starving) state_d = DGNT;
        else if (iREN)         state_d = IGNT;
      end
      IGNT: begin
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN = 1'b1;
          if (ramstate == RS_ACCESS) begin
            i_done  = 1'b1;
            iwait   = 1'b0;
            iload   = ramload;
            state_d = IDLE;
          end else if (ramstate == RS_ERROR) begin
            ramerr  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          ramWEN = dWEN;
          ramREN = dREN & ~dWEN;
          if (ramstate == RS_ACCESS) begin
            d_done  = 1'b1;
            dwait   = 1'b0;
            dload   = ramload;
            state_d = IDLE;
          end else if (ramstate == RS_ERROR) begin
            ramerr  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!iREN || i_done)
      starve_cnt_d = '0;
    else if (d_done && starve_cnt_q != LIMIT)
      starve_cnt_d = starve_cnt_q + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// random traffic compared every cycle against a grant/starvation model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = 2'b00;
  logic        iwait, dwait, ramREN, ramWEN, ramerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN),
    .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .ramstate(ramstate),
    .ramload(ramload), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN),
    .ramWEN(ramWEN), .ramerr(ramerr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Model: who holds the grant (0 none, 1 icache, 2 dcache) and how many data
  // completions in a row the icache has sat through.
  int m_grant = 0, m_starve = 0, p_grant = 0, p_starve = 0;

  always @(negedge CLK) begin
    bit          dreq, e_ren, e_wen, e_iw, e_dw, e_err;
    logic [31:0] e_addr, e_store, e_il, e_dl;
    dreq = dREN || dWEN;
    e_ren = 0; e_wen = 0; e_err = 0; e_iw = iREN; e_dw = dreq;
    e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
    p_grant = m_grant;
    p_starve = iREN ? m_starve : 0;
    if (m_grant == 0) begin
      if (dreq && !(iREN && m_starve == LIMIT)) p_grant = 2;
      else if (iREN)                            p_grant = 1;
    end else if (m_grant == 1) begin
      e_addr = iaddr;
      if (!iREN) p_grant = 0;
      else begin
        e_ren = 1;
        if (ramstate == 2'b10) begin
          e_iw = 0; e_il = ramload; p_grant = 0; p_starve = 0;
        end else if (ramstate == 2'b11) begin
          e_err = 1; p_grant = 0;
        end
      end
    end else begin
      e_addr = daddr; e_store = dstore;
      if (!dreq) p_grant = 0;
      else begin
        e_wen = dWEN; e_ren = dREN && !dWEN;
        if (ramstate == 2'b10) begin
          e_dw = 0; e_dl = ramload; p_grant = 0;
          if (iREN) p_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
        end else if (ramstate == 2'b11) begin
          e_err = 1; p_grant = 0;
        end
      end
    end
    if (!nRST) begin p_grant = 0; p_starve = 0; end
    if (chk_en) begin
      chk("m_ramREN",   32'(ramREN),   32'(e_ren));
      chk("m_ramWEN",   32'(ramWEN),   32'(e_wen));
      chk("m_ramaddr",  ramaddr,       e_addr);
      chk("m_ramstore", ramstore,      e_store);
      chk("m_iwait",    32'(iwait),    32'(e_iw));
      chk("m_dwait",    32'(dwait),    32'(e_dw));
      chk("m_iload",    iload,         e_il);
      chk("m_dload",    dload,         e_dl);
      chk("m_ramerr",   32'(ramerr),   32'(e_err));
      chk("m_exclusive", 32'(ramREN & ramWEN), 32'd0);
    end
  end

  always @(posedge CLK) begin
    m_grant  = p_grant;
    m_starve = p_starve;
  end

  initial begin
    int  writes;
    bit  found;
    step(); step();
    chk_en = 1'b1;
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_iwait", 32'(iwait), 32'd0);
    nRST = 1'b1;

    // Instruction fetch with two BUSY cycles.
    iREN = 1; iaddr = 32'h40;
    #2 chk("a_idle_ren", 32'(ramREN), 32'd0);
    step(); ramstate = 2'b01;
    #2 chk("a_ignt_addr", ramaddr, 32'h40); chk("a_ignt_ren", 32'(ramREN), 32'd1);
    chk("a_busy_iwait", 32'(iwait), 32'd1);
    step();
    #2 chk("a_busy2_ren", 32'(ramREN), 32'd1);
    step(); ramstate = 2'b10; ramload = 32'h8C220000;
    #2 chk("a_done_iwait", 32'(iwait), 32'd0); chk("a_done_iload", iload, 32'h8C220000);
    step(); iREN = 0; ramstate = 2'b00;
    #2 chk("a_idle_after", 32'(ramREN), 32'd0); chk("a_iload_zero", iload, 32'd0);
    $display("txn A: ifetch 0x40 -> 0x8C220000");

    // Simultaneous requests: data goes first.
    step(); iREN = 1; dREN = 1; daddr = 32'h100; iaddr = 32'h200;
    step(); ramstate = 2'b10; ramload = 32'h11;
    #2 chk("b_dgnt_addr", ramaddr, 32'h100); chk("b_dgnt_ren", 32'(ramREN), 32'd1);
    chk("b_iwait_hi", 32'(iwait), 32'd1); chk("b_dload", dload, 32'h11);
    step(); dREN = 0; ramstate = 2'b00;
    #2 chk("b_idle_iwait", 32'(iwait), 32'd1);
    step(); ramstate = 2'b10;
    #2 chk("b_ignt_addr", ramaddr, 32'h200); chk("b_ignt_iwait", 32'(iwait), 32'd0);
    step(); iREN = 0; ramstate = 2'b00;
    $display("txn B: dread 0x100 then ifetch 0x200");

    // Starvation bound with continuous data writes.
    iREN = 1; dWEN = 1; daddr = 32'h300; ramstate = 2'b10;
    writes = 0; found = 0;
    for (int k = 0; k < 20; k++) begin
      #2;
      if (ramWEN && !dwait) writes++;
      if (ramREN && !iwait) begin found = 1; break; end
      step();
    end
    chk("c_ignt_found", 32'(found), 32'd1);
    chk("c_write_count", 32'(writes), 32'(LIMIT));
    step();
    #2 chk("c_idle_wen", 32'(ramWEN), 32'd0);
    step();
    #2 chk("c_regrant_d", 32'(ramWEN), 32'd1);
    step(); iREN = 0; dWEN = 0; ramstate = 2'b00;
    $display("txn C: %0d writes before forced ifetch", writes);

    // RAM error on a data write, then re-grant.
    dWEN = 1; dstore = 32'hDEADBEEF; daddr = 32'h8;
    step(); ramstate = 2'b11;
    #2 chk("d_ramerr", 32'(ramerr), 32'd1); chk("d_dwait", 32'(dwait), 32'd1);
    chk("d_store", ramstore, 32'hDEADBEEF);
    step(); ramstate = 2'b00;
    #2 chk("d_err_pulse", 32'(ramerr), 32'd0); chk("d_idle_wen", 32'(ramWEN), 32'd0);
    step();
    #2 chk("d_regrant", 32'(ramWEN), 32'd1);
    $display("txn D: write 0xDEADBEEF error and retry");

    // Drop during BUSY, then reset during an instruction grant.
    dWEN = 0; dREN = 1; ramstate = 2'b01;
    #2 chk("e_busy_ren", 32'(ramREN), 32'd1);
    step(); dREN = 0;
    #2 chk("e_drop_ren", 32'(ramREN), 32'd0);
    step();
    #2 chk("e_idle_ren", 32'(ramREN), 32'd0);
    iREN = 1; iaddr = 32'h44;
    step();
    #2 chk("e_ignt_ren", 32'(ramREN), 32'd1);
    step(); nRST = 0;
    step();
    #2 chk("e_rst_ren", 32'(ramREN), 32'd0); chk("e_rst_iwait", 32'(iwait), 32'd1);
    nRST = 1; iREN = 0;
    step();
    $display("txn E: drop and reset abandon");

    // Random traffic, sticky requests, occasional reset.
    for (int c = 0; c < 2000; c++) begin
      int r;
      step();
      if ($urandom % 4 == 0) iREN = $urandom % 2;
      if ($urandom % 4 == 0) dREN = $urandom % 2;
      if ($urandom % 5 == 0) dWEN = $urandom % 2;
      if ($urandom % 3 == 0) iaddr = $urandom;
      if ($urandom % 3 == 0) daddr = $urandom;
      dstore = $urandom; ramload = $urandom;
      r = $urandom % 8;
      ramstate = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
      nRST = ($urandom % 64) != 0;
    end
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
